// File: rtl/alu_busy_ctrl.sv
// alu_busy_ctrl: busy/writeback tracking for up to two ALU lanes.
//   Each lane accepts a one-hot issue from the issue selector. It runs for
//   lat+1 cycles and then waits for the shared writeback bus. A round-robin
//   arbiter with a grant lock picks which waiting lane presents its result.
// Ports:
//   clk, rst (sync, active-high), ce (clock enable)
//   issue0/lat0, issue1/lat1 : one-hot issue vector + extra execute cycles
//   flush                    : branch-miss flush, drops all in-flight work
//   wb_ready                 : result bus accepts the presented result
//   alu0_idle, alu1_idle     : lane can accept an issue (registered state only)
//   wb_v, wb_tag, wb_alu     : presented result (tag/lane zero when !wb_v)
//   issue_err                : sticky protocol-error flag (cleared by rst)

// One ALU lane: IDLE -> EXEC (cnt down) -> WAIT (request writeback) -> IDLE.
module alu_busy_lane #(
   parameter int IQ_ENTRIES = 8,
   parameter int TAGW       = 3,
   parameter int LATW       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  i_en,
   input  logic                  i_flush,
   input  logic [IQ_ENTRIES-1:0] i_issue,
   input  logic [LATW-1:0]       i_lat,
   input  logic                  i_accept,
   output logic                  o_idle,
   output logic                  o_wait,
   output logic [TAGW-1:0]       o_tag,
   output logic                  o_err
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

   state_t            r_state, w_state_nxt;
   logic [LATW-1:0]   r_cnt, w_cnt_nxt;
   logic [TAGW-1:0]   r_tag, w_tag_nxt;
   logic [TAGW-1:0]   w_enc;
   logic              w_onehot;

   // OR-encoding is exact for a one-hot vector; other vectors are rejected anyway.
   always_comb begin
      w_enc = '0;
      for (int i = 0; i < IQ_ENTRIES; i++)
         if (i_issue[i]) w_enc = w_enc | TAGW'(i);
      w_onehot = (i_issue != '0) && ((i_issue & (i_issue - IQ_ENTRIES'(1))) == '0);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tag_nxt   = r_tag;
      if (!i_en || i_flush) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_onehot) begin
               w_tag_nxt   = w_enc;
               w_cnt_nxt   = i_lat;
               w_state_nxt = (i_lat == '0) ? S_WAIT : S_EXEC;
            end
            S_EXEC: begin
               w_cnt_nxt = r_cnt - LATW'(1);
               if (r_cnt == LATW'(1)) w_state_nxt = S_WAIT;
            end
            S_WAIT: if (i_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_tag   <= '0;
      end else if (ce) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tag   <= w_tag_nxt;
      end
   end

   assign o_idle = (r_state == S_IDLE);
   assign o_wait = (r_state == S_WAIT);
   assign o_tag  = r_tag;
   // A flush discards the issue entirely, so it is not judged for protocol errors.
   assign o_err  = ce && i_en && !i_flush && (i_issue != '0) &&
                   ((r_state != S_IDLE) || !w_onehot);
endmodule

module alu_busy_ctrl #(
   parameter int IQ_ENTRIES = 8,
   parameter int TAGW       = 3,
   parameter int LATW       = 4,
   parameter int NUM_ALU    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [IQ_ENTRIES-1:0] issue0,
   input  logic [LATW-1:0]       lat0,
   input  logic [IQ_ENTRIES-1:0] issue1,
   input  logic [LATW-1:0]       lat1,
   input  logic                  flush,
   input  logic                  wb_ready,
   output logic                  alu0_idle,
   output logic                  alu1_idle,
   output logic                  wb_v,
   output logic [TAGW-1:0]       wb_tag,
   output logic                  wb_alu,
   output logic                  issue_err
);
   logic [1:0][IQ_ENTRIES-1:0] w_issue;
   logic [1:0][LATW-1:0]       w_lat;
   logic [1:0][TAGW-1:0]       w_tag;
   logic [1:0]                 w_idle, w_wait, w_err, w_accept;
   logic                       w_grant, w_xfer;
   logic                       r_lock, r_lock_lane, r_last_grant, r_err;

   assign w_issue = {issue1, issue0};
   assign w_lat   = {lat1, lat0};

   for (genvar g = 0; g < 2; g++) begin : g_lane
      alu_busy_lane #(.IQ_ENTRIES(IQ_ENTRIES), .TAGW(TAGW), .LATW(LATW)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .ce      (ce),
         .i_en    ((g == 0) || (NUM_ALU > 1)),
         .i_flush (flush),
         .i_issue (w_issue[g]),
         .i_lat   (w_lat[g]),
         .i_accept(w_accept[g]),
         .o_idle  (w_idle[g]),
         .o_wait  (w_wait[g]),
         .o_tag   (w_tag[g]),
         .o_err   (w_err[g])
      );
   end

   // A stalled presentation stays locked on its lane; otherwise both waiting
   // lanes alternate, and a single waiting lane simply wins.
   always_comb begin
      if (r_lock)                      w_grant = r_lock_lane;
      else if (w_wait[0] && w_wait[1]) w_grant = ~r_last_grant;
      else                             w_grant = w_wait[1];
   end

   assign wb_v     = |w_wait;
   assign w_xfer   = ce && !flush && wb_v && wb_ready;
   assign w_accept = {w_xfer && w_grant, w_xfer && !w_grant};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock       <= 1'b0;
         r_lock_lane  <= 1'b0;
         r_last_grant <= 1'b1;
         r_err        <= 1'b0;
      end else if (ce) begin
         r_err <= r_err || (|w_err);
         if (flush) begin
            r_lock <= 1'b0;
         end else if (wb_v && !wb_ready) begin
            r_lock      <= 1'b1;
            r_lock_lane <= w_grant;
         end else begin
            r_lock <= 1'b0;
         end
         if (w_xfer) r_last_grant <= w_grant;
      end
   end

   assign alu0_idle = w_idle[0];
   assign alu1_idle = w_idle[1] && (NUM_ALU > 1);
   assign wb_tag    = wb_v ? w_tag[w_grant] : '0;
   assign wb_alu    = wb_v && w_grant;
   assign issue_err = r_err;
endmodule
